// File: rtl/fp_add_normalize_if.sv
// -----------------------------------------------------------------------------
// fp_add_normalize_if
// Bundle of the upstream (leading-one detector side) and downstream
// (rounding/pack side) handshake and payload signals of the normalization
// stage.
//   slave  : view taken by fp_add_normalize (consumes in_*, produces out_*)
//   master : view taken by the surrounding logic / environment
// Upstream   : in_valid, in_ready, in_sign, in_carry, in_mant, in_lead, in_exp
// Downstream : out_valid, out_ready, out_sign, out_mant, out_exp,
//              out_lost, out_zero, out_underflow, out_overflow
// -----------------------------------------------------------------------------
interface fp_add_normalize_if #(
    parameter int MANT_W = 24,
    parameter int EXP_W  = 8
) ();
    logic              in_valid;
    logic              in_ready;
    logic              in_sign;
    logic              in_carry;
    logic [MANT_W-1:0] in_mant;
    logic [MANT_W-1:0] in_lead;
    logic [EXP_W-1:0]  in_exp;

    logic              out_valid;
    logic              out_ready;
    logic              out_sign;
    logic [MANT_W-1:0] out_mant;
    logic [EXP_W-1:0]  out_exp;
    logic              out_lost;
    logic              out_zero;
    logic              out_underflow;
    logic              out_overflow;

    modport slave (
        input  in_valid, in_sign, in_carry, in_mant, in_lead, in_exp, out_ready,
        output in_ready, out_valid, out_sign, out_mant, out_exp,
               out_lost, out_zero, out_underflow, out_overflow
    );

    modport master (
        output in_valid, in_sign, in_carry, in_mant, in_lead, in_exp, out_ready,
        input  in_ready, out_valid, out_sign, out_mant, out_exp,
               out_lost, out_zero, out_underflow, out_overflow
    );
endinterface

// File: rtl/fp_add_normalize.sv
// -----------------------------------------------------------------------------
// fp_add_normalize
// Normalization stage of the floating-point adder, directly downstream of the
// leading-one detector. Two-stage pipeline with valid/ready on both sides:
//   stage 1 registers the operands plus the left-shift distance derived from
//           the leading-one vector and a "no leading one" flag;
//   stage 2 registers the normalized mantissa, adjusted exponent and the
//           exception flags (lost bit, zero, underflow, overflow).
// Ports:
//   clk    : clock, all state on rising edge
//   rst_n  : asynchronous active-low reset, clears both stages and outputs
//   bus    : fp_add_normalize_if.slave (upstream + downstream handshake/data)
// -----------------------------------------------------------------------------
module fp_add_normalize #(
    parameter int MANT_W  = 24,
    parameter int EXP_W   = 8,
    parameter int SHIFT_W = 5
) (
    input  logic                 clk,
    input  logic                 rst_n,
    fp_add_normalize_if.slave    bus
);

    localparam logic [SHIFT_W-1:0] TOP_IDX = SHIFT_W'(MANT_W - 1);
    localparam logic [EXP_W:0]     EXP_MAX = {1'b0, {EXP_W{1'b1}}};

    // Handshake
    logic               s2_accept_s;
    logic               in_ready_s;
    logic               in_fire_s;

    // Leading-one encode
    logic [SHIFT_W-1:0] lead_idx_s;
    logic [SHIFT_W-1:0] shift_s;

    // Stage 1 registers
    logic               s1_valid_r;
    logic               s1_sign_r;
    logic               s1_carry_r;
    logic [MANT_W-1:0]  s1_mant_r;
    logic [EXP_W-1:0]   s1_exp_r;
    logic [SHIFT_W-1:0] s1_shift_r;
    logic               s1_lead_zero_r;

    // Stage 2 next values
    logic [EXP_W:0]     exp_inc_s;
    logic [EXP_W:0]     exp_sub_s;
    logic [MANT_W-1:0]  nxt_mant_s;
    logic [EXP_W-1:0]   nxt_exp_s;
    logic               nxt_lost_s;
    logic               nxt_zero_s;
    logic               nxt_underflow_s;
    logic               nxt_overflow_s;

    // Stage 2 (output) registers
    logic               s2_valid_r;
    logic               out_sign_r;
    logic [MANT_W-1:0]  out_mant_r;
    logic [EXP_W-1:0]   out_exp_r;
    logic               out_lost_r;
    logic               out_zero_r;
    logic               out_underflow_r;
    logic               out_overflow_r;

    // in_ready depends combinationally only on out_ready and local state.
    assign s2_accept_s = !s2_valid_r || bus.out_ready;
    assign in_ready_s  = !s1_valid_r || s2_accept_s;
    assign in_fire_s   = bus.in_valid && in_ready_s;

    // Encode the leading-one vector; the highest set bit wins so that a
    // multi-hot vector from the detector still yields a sane shift.
    always_comb begin
        lead_idx_s = {SHIFT_W{1'b0}};
        for (int i = 0; i < MANT_W; i++) begin
            lead_idx_s = bus.in_lead[i] ? SHIFT_W'(i) : lead_idx_s;
        end
    end

    assign shift_s = TOP_IDX - lead_idx_s;

    // Stage 1: capture operands and the derived shift distance on accept.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_r     <= 1'b0;
            s1_sign_r      <= 1'b0;
            s1_carry_r     <= 1'b0;
            s1_mant_r      <= {MANT_W{1'b0}};
            s1_exp_r       <= {EXP_W{1'b0}};
            s1_shift_r     <= {SHIFT_W{1'b0}};
            s1_lead_zero_r <= 1'b0;
        end else if (in_fire_s) begin
            s1_valid_r     <= 1'b1;
            s1_sign_r      <= bus.in_sign;
            s1_carry_r     <= bus.in_carry;
            s1_mant_r      <= bus.in_mant;
            s1_exp_r       <= bus.in_exp;
            s1_shift_r     <= shift_s;
            s1_lead_zero_r <= (bus.in_lead == {MANT_W{1'b0}});
        end else if (s2_accept_s) begin
            s1_valid_r     <= 1'b0;
        end
    end

    // Exponent arithmetic is one bit wider than the field so that the carry
    // into 255 and the borrow below zero are both visible.
    assign exp_inc_s = {1'b0, s1_exp_r} + {{EXP_W{1'b0}}, 1'b1};
    assign exp_sub_s = {1'b0, s1_exp_r} - {{(EXP_W + 1 - SHIFT_W){1'b0}}, s1_shift_r};

    // Stage 2 result selection: Inf/NaN, carry, exact zero, flush, normal shift.
    always_comb begin
        nxt_mant_s      = {MANT_W{1'b0}};
        nxt_exp_s       = {EXP_W{1'b0}};
        nxt_lost_s      = 1'b0;
        nxt_zero_s      = 1'b0;
        nxt_underflow_s = 1'b0;
        nxt_overflow_s  = 1'b0;
        if (s1_exp_r == {EXP_W{1'b1}}) begin
            nxt_mant_s = s1_mant_r;
            nxt_exp_s  = s1_exp_r;
        end else if (s1_carry_r) begin
            nxt_lost_s = s1_mant_r[0];
            if (exp_inc_s == EXP_MAX) begin
                nxt_overflow_s = 1'b1;
                nxt_exp_s      = {EXP_W{1'b1}};
            end else begin
                nxt_mant_s = {1'b1, s1_mant_r[MANT_W-1:1]};
                nxt_exp_s  = exp_inc_s[EXP_W-1:0];
            end
        end else if (s1_lead_zero_r) begin
            nxt_zero_s = 1'b1;
        end else if (exp_sub_s[EXP_W] || (exp_sub_s == {(EXP_W + 1){1'b0}})) begin
            // exp <= shift: borrow out or exact zero; no denormals, flush.
            nxt_underflow_s = 1'b1;
        end else begin
            nxt_mant_s = s1_mant_r << s1_shift_r;
            nxt_exp_s  = exp_sub_s[EXP_W-1:0];
        end
    end

    // Stage 2: output register, holds while the downstream stalls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid_r      <= 1'b0;
            out_sign_r      <= 1'b0;
            out_mant_r      <= {MANT_W{1'b0}};
            out_exp_r       <= {EXP_W{1'b0}};
            out_lost_r      <= 1'b0;
            out_zero_r      <= 1'b0;
            out_underflow_r <= 1'b0;
            out_overflow_r  <= 1'b0;
        end else if (s2_accept_s) begin
            s2_valid_r <= s1_valid_r;
            if (s1_valid_r) begin
                out_sign_r      <= s1_sign_r;
                out_mant_r      <= nxt_mant_s;
                out_exp_r       <= nxt_exp_s;
                out_lost_r      <= nxt_lost_s;
                out_zero_r      <= nxt_zero_s;
                out_underflow_r <= nxt_underflow_s;
                out_overflow_r  <= nxt_overflow_s;
            end
        end
    end

    assign bus.in_ready      = in_ready_s;
    assign bus.out_valid     = s2_valid_r;
    assign bus.out_sign      = out_sign_r;
    assign bus.out_mant      = out_mant_r;
    assign bus.out_exp       = out_exp_r;
    assign bus.out_lost      = out_lost_r;
    assign bus.out_zero      = out_zero_r;
    assign bus.out_underflow = out_underflow_r;
    assign bus.out_overflow  = out_overflow_r;

endmodule

// File: tb/tb_fp_add_normalize.sv
// -----------------------------------------------------------------------------
// tb_fp_add_normalize
// Self-checking bench for fp_add_normalize: directed corner vectors with
// latency checks, a backpressure burst, a randomized stream against an
// arithmetic reference model, and an asynchronous reset while data is in
// flight.
// -----------------------------------------------------------------------------
module tb_fp_add_normalize;

    typedef struct packed {
        logic        sign;
        logic [23:0] mant;
        logic [7:0]  exp;
        logic        lost;
        logic        zero;
        logic        unf;
        logic        ovf;
    } res_t;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;
    res_t exp_q[$];
    res_t last_out;
    bit   prev_stall;

    fp_add_normalize_if #(.MANT_W(24), .EXP_W(8)) bus ();

    fp_add_normalize #(.MANT_W(24), .EXP_W(8), .SHIFT_W(5)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
        end
    endtask

    // Reference: value-level arithmetic on the normalization rules.
    function automatic res_t model(input logic s, input logic c, input logic [23:0] m,
                                   input logic [23:0] l, input logic [7:0] e);
        res_t r;
        int   p;
        int   sh;
        int   ev;
        r      = '0;
        r.sign = s;
        p      = $clog2(int'(l) + 1) - 1;   // floor(log2(l)), -1 when l == 0
        if (e == 8'hFF) begin
            r.mant = m;
            r.exp  = 8'hFF;
        end else if (c) begin
            ev     = int'(e) + 1;
            r.lost = m[0];
            if (ev >= 255) begin
                r.ovf = 1'b1;
                r.exp = 8'hFF;
            end else begin
                r.mant = 24'(int'(m) / 2 + 8388608);
                r.exp  = 8'(ev);
            end
        end else if (p < 0) begin
            r.zero = 1'b1;
        end else begin
            sh = 23 - p;
            if (int'(e) <= sh) begin
                r.unf = 1'b1;
            end else begin
                r.mant = 24'((longint'(m) * (longint'(1) << sh)) % 64'd16777216);
                r.exp  = 8'(int'(e) - sh);
            end
        end
        return r;
    endfunction

    function automatic res_t observe();
        return {bus.out_sign, bus.out_mant, bus.out_exp, bus.out_lost,
                bus.out_zero, bus.out_underflow, bus.out_overflow};
    endfunction

    task automatic rand_vec(output logic s, output logic c, output logic [23:0] m,
                            output logic [23:0] l, output logic [7:0] e);
        int p;
        int sel;
        int lowmask;
        p       = $urandom_range(0, 23);
        lowmask = (1 << p) - 1;
        m       = 24'((1 << p) | (int'($urandom) & lowmask));
        l       = 24'(1 << p);
        s       = 1'($urandom_range(0, 1));
        c       = ($urandom_range(0, 3) == 0);
        sel     = $urandom_range(0, 9);
        if (sel == 0) begin
            m = 24'd0;
            l = 24'd0;
        end else if (sel == 1) begin
            l = 24'((1 << p) | (int'($urandom) & lowmask));
        end
        if (c) m = 24'($urandom);
        sel = $urandom_range(0, 5);
        case (sel)
            0:       e = 8'hFF;
            1:       e = 8'hFE;
            2:       e = 8'($urandom_range(0, 24));
            default: e = 8'($urandom_range(1, 254));
        endcase
    endtask

    // One clock cycle: drive at the falling edge, observe 1 time unit later,
    // score whatever transfers will happen on the coming rising edge.
    task automatic cyc(input logic v, input logic s, input logic c, input logic [23:0] m,
                       input logic [23:0] l, input logic [7:0] e, input logic ordy,
                       output logic took);
        res_t o;
        res_t x;
        @(negedge clk);
        bus.in_valid  = v;
        bus.in_sign   = s;
        bus.in_carry  = c;
        bus.in_mant   = m;
        bus.in_lead   = l;
        bus.in_exp    = e;
        bus.out_ready = ordy;
        #1;
        chk("in_ready", 64'(bus.in_ready), 64'(!(exp_q.size() == 2 && !ordy)));
        if (exp_q.size() == 0) chk("idle_out_valid", 64'(bus.out_valid), 64'd0);
        o = observe();
        if (prev_stall) begin
            chk("stall_valid", 64'(bus.out_valid), 64'd1);
            chk("stall_hold", 64'(o), 64'(last_out));
        end
        if (bus.out_valid && ordy && exp_q.size() > 0) begin
            x = exp_q.pop_front();
            chk("res_mant", 64'(o.mant), 64'(x.mant));
            chk("res_exp", 64'(o.exp), 64'(x.exp));
            chk("res_flags", 64'({o.sign, o.lost, o.zero, o.unf, o.ovf}),
                64'({x.sign, x.lost, x.zero, x.unf, x.ovf}));
        end
        took = v && bus.in_ready;
        if (took) exp_q.push_back(model(s, c, m, l, e));
        prev_stall = bus.out_valid && !ordy;
        last_out   = o;
    endtask

    task automatic idle(input logic ordy);
        logic took;
        cyc(1'b0, 1'b0, 1'b0, 24'd0, 24'd0, 8'd0, ordy, took);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() > 0 && n < 20) begin
            idle(1'b1);
            n++;
        end
        chk("drain_empty", 64'(exp_q.size()), 64'd0);
    endtask

    // Single item into an empty pipe: checks 2-cycle latency and spec constants.
    task automatic directed(input string tag, input logic s, input logic c, input logic [23:0] m,
                            input logic [23:0] l, input logic [7:0] e, input logic [23:0] em,
                            input logic [7:0] ee, input logic [3:0] ef);
        logic took;
        cyc(1'b1, s, c, m, l, e, 1'b1, took);
        chk({tag, "_accept"}, 64'(took), 64'd1);
        idle(1'b1);
        chk({tag, "_lat1"}, 64'(bus.out_valid), 64'd0);
        idle(1'b1);
        chk({tag, "_lat2"}, 64'(bus.out_valid), 64'd1);
        chk({tag, "_mant"}, 64'(bus.out_mant), 64'(em));
        chk({tag, "_exp"}, 64'(bus.out_exp), 64'(ee));
        chk({tag, "_flags"}, 64'({bus.out_lost, bus.out_zero, bus.out_underflow, bus.out_overflow}),
            64'(ef));
        chk({tag, "_sign"}, 64'(bus.out_sign), 64'(s));
    endtask

    initial begin
        logic        s_v;
        logic        c_v;
        logic [23:0] m_v;
        logic [23:0] l_v;
        logic [7:0]  e_v;
        logic        took;
        logic        saw_block;
        logic        v_r;
        int          sent;
        int          k;

        checks        = 0;
        errors        = 0;
        prev_stall    = 1'b0;
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_sign   = 1'b0;
        bus.in_carry  = 1'b0;
        bus.in_mant   = 24'd0;
        bus.in_lead   = 24'd0;
        bus.in_exp    = 8'd0;
        bus.out_ready = 1'b0;

        // Reset state
        #12;
        chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_in_ready", 64'(bus.in_ready), 64'd1);
        chk("rst_out_data", 64'(observe()), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed corner vectors                 sign  carry mant         lead         exp    out_mant     out_exp  {lost,zero,unf,ovf}
        directed("carry",     1'b0, 1'b1, 24'h000003, 24'h000002, 8'h80, 24'h800001, 8'h81, 4'b1000);
        directed("lshift",    1'b0, 1'b0, 24'h001234, 24'h001000, 8'h90, 24'h91A000, 8'h85, 4'b0000);
        directed("zero",      1'b1, 1'b0, 24'h000000, 24'h000000, 8'h70, 24'h000000, 8'h00, 4'b0100);
        directed("underflow", 1'b1, 1'b0, 24'h040001, 24'h040000, 8'h05, 24'h000000, 8'h00, 4'b0010);
        directed("exp_min",   1'b0, 1'b0, 24'h040001, 24'h040000, 8'h06, 24'h800020, 8'h01, 4'b0000);
        directed("overflow",  1'b1, 1'b1, 24'h000002, 24'h000002, 8'hFE, 24'h000000, 8'hFF, 4'b0001);
        directed("infnan",    1'b0, 1'b1, 24'h400000, 24'h400000, 8'hFF, 24'h400000, 8'hFF, 4'b0000);
        directed("multihot",  1'b0, 1'b0, 24'h00F000, 24'h00F000, 8'h40, 24'hF00000, 8'h38, 4'b0000);
        directed("normed",    1'b0, 1'b0, 24'h812345, 24'h800000, 8'h10, 24'h812345, 8'h10, 4'b0000);

        // Backpressure: 6 items back-to-back, downstream stalled for 3 cycles
        sent      = 0;
        k         = 0;
        saw_block = 1'b0;
        rand_vec(s_v, c_v, m_v, l_v, e_v);
        while (sent < 6 && k < 40) begin
            cyc(1'b1, s_v, c_v, m_v, l_v, e_v, (k >= 2 && k <= 4) ? 1'b0 : 1'b1, took);
            if (took) begin
                sent++;
                rand_vec(s_v, c_v, m_v, l_v, e_v);
            end else begin
                saw_block = 1'b1;
            end
            k++;
        end
        chk("bp_sent", 64'(sent), 64'd6);
        chk("bp_in_ready_low", 64'(saw_block), 64'd1);
        drain();

        // Randomized stream with random backpressure
        rand_vec(s_v, c_v, m_v, l_v, e_v);
        for (int i = 0; i < 400; i++) begin
            v_r = ($urandom_range(0, 3) != 0);
            cyc(v_r, s_v, c_v, m_v, l_v, e_v, ($urandom_range(0, 9) < 7), took);
            if (took) rand_vec(s_v, c_v, m_v, l_v, e_v);
        end
        drain();

        // Asynchronous reset with both stages occupied
        rand_vec(s_v, c_v, m_v, l_v, e_v);
        cyc(1'b1, s_v, c_v, m_v, l_v, e_v, 1'b0, took);
        rand_vec(s_v, c_v, m_v, l_v, e_v);
        cyc(1'b1, s_v, c_v, m_v, l_v, e_v, 1'b0, took);
        @(posedge clk);
        #1;
        chk("pre_rst_valid", 64'(bus.out_valid), 64'd1);
        #1;
        rst_n = 1'b0;
        #1;
        chk("async_rst_valid", 64'(bus.out_valid), 64'd0);
        chk("async_rst_data", 64'(observe()), 64'd0);
        chk("async_rst_in_ready", 64'(bus.in_ready), 64'd1);
        exp_q.delete();
        prev_stall = 1'b0;
        bus.in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        directed("post_rst",  1'b1, 1'b0, 24'h001234, 24'h001000, 8'h90, 24'h91A000, 8'h85, 4'b0000);
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fp_add_normalize.md
Name: fp_add_normalize

Overview:
- Normalization stage of the floating-point adder. Sits directly downstream of the 24-bit leading-one detector.
- Consumes the raw mantissa sum, the adder carry-out, the one-hot leading-one vector and the pre-normalization exponent.
- Produces a normalized 24-bit mantissa (hidden bit at [23]), an adjusted exponent and exception flags.
- 2-stage pipeline with valid/ready handshake on both sides; feeds the rounding/pack stage.

Parameters:
MANT_W, 24, mantissa width including hidden bit
EXP_W, 8, biased exponent width
SHIFT_W, 5, shift-count width (ceil(log2(MANT_W)))

Ports:
clk  input  1  clock, all state on rising edge
rst_n  input  1  reset, asynchronous, active-low
in_valid  input  1  upstream data valid
in_ready  output  1  stage can accept this cycle
in_sign  input  1  result sign
in_carry  input  1  mantissa adder carry-out
in_mant  input  MANT_W  raw mantissa sum
in_lead  input  MANT_W  one-hot leading-one vector from detector (all-zero when in_mant==0)
in_exp  input  EXP_W  biased exponent before normalization
out_valid  output  1  result valid
out_ready  input  1  downstream accepts
out_sign  output  1  sign, passed through
out_mant  output  MANT_W  normalized mantissa
out_exp  output  EXP_W  adjusted biased exponent
out_lost  output  1  bit shifted out on right-shift (carry case), else 0
out_zero  output  1  exact-zero result
out_underflow  output  1  result flushed to zero
out_overflow  output  1  result saturated to infinity

Behaviour:
- Reset (rst_n low, async): both stage valid flags 0; out_valid=0; all data/flag outputs 0. Reset mid-transfer drops in-flight data with no partial output.
- Handshake:
  - Transfer on a side only when valid && ready.
  - in_ready = !s1_valid || (s1 moves to s2 this cycle).
  - s2 accepts when !s2_valid || out_ready.
  - in_ready is combinational from out_ready; nothing else on that path.
  - Once out_valid=1, outputs hold stable until out_ready.
- Latency: 2 cycles from input accept to out_valid. Throughput: 1 result/cycle with no stalls.
- Stage 1 (registers inputs plus derived values):
  - Encode in_lead to bit index p using the highest set bit; a multi-hot vector is tolerated and must not corrupt results.
  - Compute shift = 23 - p.
  - Register lead_zero = (in_lead == 0).
- Stage 2 (case priority in this order):
  1. in_exp == 255 (Inf/NaN): pass exponent and mantissa unchanged; all flags 0.
  2. in_carry == 1: out_mant = {1, in_mant[23:1]}; out_lost = in_mant[0]; out_exp = in_exp + 1. If in_exp + 1 == 255: out_overflow=1, out_exp=255, out_mant=0.
  3. lead_zero: out_zero=1, out_exp=0, out_mant=0.
  4. in_exp <= shift: out_underflow=1, out_exp=0, out_mant=0 (flush-to-zero; no denormals).
  5. Otherwise: out_mant = in_mant << shift, zero-filled; out_exp = in_exp - shift. out_mant[23] must be 1.
- out_sign always passes through unchanged, including for zero, underflow and overflow results.
- Exponent arithmetic:
  - Done at EXP_W+1 bits internally.
  - Exponent never wraps past 255 or below 0.

Test Plan:
- Carry case: in_carry=1, in_mant=0x000003, in_exp=0x80 -> out_mant=0x800001, out_exp=0x81, out_lost=1, 2 cycles after accept.
- Left shift: in_mant=0x001234, in_lead=0x001000, in_exp=0x90 -> shift=11, out_mant=0x91A000, out_exp=0x85.
- Boundaries:
  - in_mant=0, in_lead=0 -> out_zero=1, out_exp=0.
  - in_exp=0x05 with shift=5 -> out_underflow=1, out_mant=0.
  - in_carry=1, in_exp=0xFE -> out_overflow=1, out_exp=0xFF, out_mant=0.
- Backpressure:
  - Stream 6 back-to-back inputs with out_ready low for cycles 3-5 -> no loss or duplication; in_ready low while both stages full; results in order.
  - Outputs stable while stalled.
- Reset mid-operation: assert rst_n low asynchronously while 2 items are in flight -> out_valid drops immediately with no clock; after release, in_ready=1 and the first new item emerges 2 cycles after accept.
